// File: rtl/frame_cfg_pkg.sv
// Shared state encoding, default sync/desync words and header field layout
// for the column frame configuration sequencer.
package frame_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HEADER = 3'd1;
  localparam state_t S_LOAD   = 3'd2;
  localparam state_t S_STROBE = 3'd3;
  localparam state_t S_HOLD   = 3'd4;
  localparam state_t S_CHECK  = 3'd5;

  localparam logic [31:0] SYNC_WORD_DEF   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD_DEF = 32'hFAB0_FAB0;

  localparam int HDR_START_LSB = 0;
  localparam int HDR_START_W   = 5;
  localparam int HDR_COUNT_LSB = 8;
  localparam int HDR_COUNT_W   = 5;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of the frame index; the strobe lines come straight
// from flops so the transparent frame latches never see a decode glitch.
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic [4:0]                 i_index,
  output logic [MaxFramesPerCol-1:0] o_strobe
);

  logic [MaxFramesPerCol-1:0] r_strobe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_strobe <= '0;
    end else begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        r_strobe[i] <= i_en && (i_index == 5'(i));
      end
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/frame_config_sequencer.sv
// Streams sync/header/payload words into one fabric column's frame latches,
// one strobe per frame with a full cycle of data setup and hold on either side.
// Optional trailer checksum: define FRAME_SEQ_CRC_EN.
module frame_config_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int                         FrameBitsPerRow = 32,
  parameter int                         MaxFramesPerCol = 20,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = SYNC_WORD_DEF,
  parameter logic [FrameBitsPerRow-1:0] DesyncWord      = DESYNC_WORD_DEF
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_t                     r_state;
  logic [4:0]                 r_index;
  logic [5:0]                 r_remain;
  logic [FrameBitsPerRow-1:0] r_frame_data;
  logic                       r_done;
  logic                       r_err;
`ifdef FRAME_SEQ_CRC_EN
  logic [FrameBitsPerRow-1:0] r_crc;
`endif

  logic       w_accept;
  logic [4:0] w_hdr_start;
  logic [4:0] w_hdr_count;
  logic [5:0] w_range_end;

  assign in_ready = (r_state == S_IDLE) || (r_state == S_HEADER) ||
                    (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_accept    = in_valid && in_ready;
  assign w_hdr_start = in_data[HDR_START_LSB +: HDR_START_W];
  assign w_hdr_count = in_data[HDR_COUNT_LSB +: HDR_COUNT_W];
  // Six-bit sum so start 31 + count 31 cannot wrap past the range check
  assign w_range_end = {1'b0, w_hdr_start} + {1'b0, w_hdr_count};

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_index      <= '0;
      r_remain     <= '0;
      r_frame_data <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef FRAME_SEQ_CRC_EN
      r_crc        <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && in_data == SyncWord) begin
            r_err   <= 1'b0;
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_accept) begin
            if (in_data == DesyncWord) begin
              r_state <= S_IDLE;
            end else if (w_hdr_count == 5'd0) begin
              r_done <= 1'b1;
            end else if (w_range_end > 6'(MaxFramesPerCol)) begin
              r_err <= 1'b1;
            end else begin
              r_index  <= w_hdr_start;
              r_remain <= {1'b0, w_hdr_count};
`ifdef FRAME_SEQ_CRC_EN
              r_crc    <= '0;
`endif
              r_state  <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_frame_data <= in_data;
`ifdef FRAME_SEQ_CRC_EN
            r_crc        <= r_crc ^ in_data;
`endif
            r_state      <= S_STROBE;
          end
        end
        S_STROBE: r_state <= S_HOLD;
        S_HOLD: begin
          r_index  <= r_index + 5'd1;
          r_remain <= r_remain - 6'd1;
          if (r_remain == 6'd1) begin
`ifdef FRAME_SEQ_CRC_EN
            r_state <= S_CHECK;
`else
            r_done  <= 1'b1;
            r_state <= S_HEADER;
`endif
          end else begin
            r_state <= S_LOAD;
          end
        end
`ifdef FRAME_SEQ_CRC_EN
        S_CHECK: begin
          if (w_accept) begin
            if (in_data != r_crc) r_err <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_HEADER;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_strobe (
    .i_clk   (CLK),
    .i_rst_n (resetn),
    .i_en    (r_state == S_STROBE),
    .i_index (r_index),
    .o_strobe(FrameStrobe)
  );

  assign FrameData = r_frame_data;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Table-driven bench for frame_config_sequencer: each record drives one cycle
// of stream input and states the outputs expected just after the next edge.
module tb_frame_config_sequencer;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] DESY = 32'hFAB0_FAB0;
  localparam logic [31:0] D1 = 32'h1111_0001, D2 = 32'h2222_0002, D3 = 32'h3333_0003;
  localparam logic [31:0] D4 = 32'h4444_0004, D5 = 32'h5555_0005;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy, done, err;

  frame_config_sequencer dut (
    .CLK        (CLK),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic [19:0] stb;
    logic [31:0] fd;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic v, input logic [31:0] d, input logic rdy,
                     input logic [19:0] stb, input logic [31:0] fd,
                     input logic b, input logic dn, input logic e);
    vec_t x;
    x.v = v; x.d = d; x.rdy = rdy; x.stb = stb; x.fd = fd;
    x.busy = b; x.done = dn; x.err = e;
    tbl.push_back(x);
  endtask

  // Final HOLD of a block; with the checksum build a trailer word follows.
  task automatic end_blk(input logic [31:0] fd, input logic e,
                         input logic [31:0] trailer, input logic trailer_err);
`ifdef FRAME_SEQ_CRC_EN
    add(0, 0, 1, 0, fd, 1, 0, e);
    add(1, trailer, 1, 0, fd, 1, 1, trailer_err);
`else
    add(0, 0, 1, 0, fd, 1, 1, e);
    if (trailer_err === 1'bx && trailer === 32'hx) n_miss++;
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(e.rdy));
    chk({tag, ".FrameStrobe"}, 32'(FrameStrobe), 32'(e.stb));
    chk({tag, ".FrameData"}, FrameData, e.fd);
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(done), 32'(e.done));
    chk({tag, ".err"}, 32'(err), 32'(e.err));
    n_vec++;
  endtask

  // Called #1 after a rising edge: drive, let one edge pass, compare.
  task automatic apply(input string tag, input vec_t x);
    vec_t e;
    in_valid = x.v;
    in_data  = x.d;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check_outs(tag, e);
  endtask

  always @(negedge CLK) begin
    if ($countones(FrameStrobe) > 1) begin
      n_miss++;
      $display("FAIL strobe_onehot: got %h, expected at most one bit", FrameStrobe);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t z;
    logic [31:0] last_fd;
    logic        last_err;

    // Single two-frame block
    add(1, SYNC,         1, 0,        0,            1, 0, 0);
    add(1, 32'h200,      1, 0,        0,            1, 0, 0);
    add(1, 32'hA5A5A5A5, 0, 0,        32'hA5A5A5A5, 1, 0, 0);
    add(0, 0,            0, 20'h1,    32'hA5A5A5A5, 1, 0, 0);
    add(0, 0,            1, 0,        32'hA5A5A5A5, 1, 0, 0);
    add(1, 32'h0000FFFF, 0, 0,        32'h0000FFFF, 1, 0, 0);
    add(0, 0,            0, 20'h2,    32'h0000FFFF, 1, 0, 0);
    end_blk(32'h0000FFFF, 0, 32'hA5A5A5A5 ^ 32'h0000FFFF, 0);
    add(0, 0,            1, 0,        32'h0000FFFF, 1, 0, 0);
    // Back-to-back data held valid, next word offered while not ready
    add(1, 32'h305,      1, 0,        32'h0000FFFF, 1, 0, 0);
    add(1, D1,           0, 0,        D1, 1, 0, 0);
    add(1, D2,           0, 20'h20,   D1, 1, 0, 0);
    add(1, D2,           1, 0,        D1, 1, 0, 0);
    add(1, D2,           0, 0,        D2, 1, 0, 0);
    add(1, D3,           0, 20'h40,   D2, 1, 0, 0);
    add(1, D3,           1, 0,        D2, 1, 0, 0);
    add(1, D3,           0, 0,        D3, 1, 0, 0);
    add(0, 0,            0, 20'h80,   D3, 1, 0, 0);
    end_blk(D3, 0, D1 ^ D2 ^ D3, 0);
    // Out-of-range header, zero-count header, desync, garbage, resync
    add(1, 32'h312,      1, 0,        D3, 1, 0, 1);
    add(0, 0,            1, 0,        D3, 1, 0, 1);
    add(1, 32'h007,      1, 0,        D3, 1, 1, 1);
    add(1, DESY,         1, 0,        D3, 0, 0, 1);
    add(1, 32'h12345678, 1, 0,        D3, 0, 0, 1);
    add(1, DESY,         1, 0,        D3, 0, 0, 1);
    add(1, SYNC,         1, 0,        D3, 1, 0, 0);
    // Block ending exactly at the last frame line
    add(1, 32'h212,      1, 0,        D3, 1, 0, 0);
    add(1, D4,           0, 0,        D4, 1, 0, 0);
    add(0, 0,            0, 20'h40000, D4, 1, 0, 0);
    add(0, 0,            1, 0,        D4, 1, 0, 0);
    add(1, D5,           0, 0,        D5, 1, 0, 0);
    add(0, 0,            0, 20'h80000, D5, 1, 0, 0);
    end_blk(D5, 0, D4 ^ D5, 0);
    last_fd  = D5;
    last_err = 1'b0;
`ifdef FRAME_SEQ_CRC_EN
    for (int k = 0; k < 2; k++) begin
      add(1, 32'h200, 1, 0,     last_fd, 1, 0, last_err);
      add(1, 32'h1,   0, 0,     32'h1,   1, 0, last_err);
      add(0, 0,       0, 20'h1, 32'h1,   1, 0, last_err);
      add(0, 0,       1, 0,     32'h1,   1, 0, last_err);
      add(1, 32'h2,   0, 0,     32'h2,   1, 0, last_err);
      add(0, 0,       0, 20'h2, 32'h2,   1, 0, last_err);
      end_blk(32'h2, last_err, (k == 0) ? 32'h3 : 32'h4, k == 1);
      last_fd  = 32'h2;
      last_err = (k == 1);
    end
`endif
    add(1, DESY, 1, 0, last_fd, 0, 0, last_err);

    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge CLK);
    #1;
    z = '{v: 0, d: 0, rdy: 1, stb: 0, fd: 0, busy: 0, done: 0, err: 0};
    check_outs("reset", z);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset asserted while in STROBE: everything clears before the strobe fires
    apply("mid_sync", '{v: 1, d: SYNC,        rdy: 1, stb: 0, fd: last_fd,    busy: 1, done: 0, err: 0});
    apply("mid_hdr",  '{v: 1, d: 32'h100,     rdy: 1, stb: 0, fd: last_fd,    busy: 1, done: 0, err: 0});
    apply("mid_data", '{v: 1, d: 32'hDEADBEEF, rdy: 0, stb: 0, fd: 32'hDEADBEEF, busy: 1, done: 0, err: 0});
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    check_outs("rst_async", z);
    apply("rst_held", z);
    resetn = 1'b1;
    apply("rst_idle", '{v: 1, d: 32'hDEADBEEF, rdy: 1, stb: 0, fd: 0, busy: 0, done: 0, err: 0});
    apply("rst_sync", '{v: 1, d: SYNC,        rdy: 1, stb: 0, fd: 0, busy: 1, done: 0, err: 0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
